// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit: operation codes, FSM states
// and the single-bit shift step used by the iterative shifter.
package alu_exec_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_NOTEQ = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SGE   = 4'd4,
    ALU_SLTU  = 4'd5,
    ALU_SGEU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_XOR   = 4'd10,
    ALU_OR    = 4'd11,
    ALU_AND   = 4'd12,
    ALU_JUMP  = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

  function automatic logic [31:0] shift_one(input logic [3:0] op, input logic [31:0] v);
    case (op)
      ALU_SLL: return {v[30:0], 1'b0};
      ALU_SRL: return {1'b0, v[31:1]};
      default: return {v[31], v[31:1]};
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result handshake bundle between the issuing stage and the ALU unit.
interface alu_exec_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        br_cond;
  logic        illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, flush, out_ready,
    input  in_ready, out_valid, result, br_cond, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, flush, out_ready,
    output in_ready, out_valid, result, br_cond, illegal
  );
endinterface

// File: rtl/alu_exec_unit_alu_comb.sv
// Single-cycle ALU datapath; shift codes are left to the iterative shifter.
module alu_comb
  import alu_exec_unit_pkg::*;
(
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result,
  output logic        br_cond,
  output logic        illegal
);

  logic lt_s;
  logic lt_u;
  logic ne;

  assign lt_s = $signed(op_a) < $signed(op_b);
  assign lt_u = op_a < op_b;
  assign ne   = op_a != op_b;

  always_comb begin
    result  = '0;
    br_cond = 1'b0;
    illegal = 1'b0;
    case (alu_ctrl)
      ALU_ADD:   result = op_a + op_b;
      ALU_SUB:   begin result = op_a - op_b; br_cond = ~ne; end
      ALU_NOTEQ: begin result = {31'd0, ne};    br_cond = ne;    end
      ALU_SLT:   begin result = {31'd0, lt_s};  br_cond = lt_s;  end
      ALU_SGE:   begin result = {31'd0, ~lt_s}; br_cond = ~lt_s; end
      ALU_SLTU:  begin result = {31'd0, lt_u};  br_cond = lt_u;  end
      ALU_SGEU:  begin result = {31'd0, ~lt_u}; br_cond = ~lt_u; end
      ALU_XOR:   result = op_a ^ op_b;
      ALU_OR:    result = op_a | op_b;
      ALU_AND:   result = op_a & op_b;
      ALU_JUMP:  result = op_a + 32'd4;
      ALU_SLL, ALU_SRL, ALU_SRA: begin end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready wrapper around the single-cycle datapath
// with an iterative one-bit-per-cycle shifter and flush support.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
(
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  state_e      state_q;
  logic [31:0] res_q;
  logic        br_q;
  logic        ill_q;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;

  logic [31:0] comb_res;
  logic        comb_br;
  logic        comb_ill;
  logic        accept;

  alu_comb u_alu_comb (
    .alu_ctrl (bus.alu_ctrl),
    .op_a     (bus.op_a),
    .op_b     (bus.op_b),
    .result   (comb_res),
    .br_cond  (comb_br),
    .illegal  (comb_ill)
  );

  // DONE re-opens the input only when its result is being consumed this cycle.
  assign bus.in_ready = ~rst & ~bus.flush &
                        ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready));
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else if (accept) begin
      op_q <= bus.alu_ctrl;
      if (is_shift_op(bus.alu_ctrl)) begin
        res_q   <= bus.op_a;
        br_q    <= 1'b0;
        ill_q   <= 1'b0;
        cnt_q   <= bus.op_b[4:0];
        state_q <= (bus.op_b[4:0] == 5'd0) ? ST_DONE : ST_SHIFT;
      end else begin
        res_q   <= comb_res;
        br_q    <= comb_br;
        ill_q   <= comb_ill;
        state_q <= ST_DONE;
      end
    end else begin
      case (state_q)
        ST_SHIFT: begin
          res_q <= shift_one(op_q, res_q);
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_q <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = res_q;
  assign bus.br_cond   = br_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;
  import alu_exec_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = op;
    bus.op_a     = a;
    bus.op_b     = b;
  endtask

  // Accept one op with out_ready=1, wait lat-1 cycles, check the result, retire.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int unsigned lat,
                        input logic [31:0] exp_res, input logic exp_br);
    bus.out_ready = 1'b1;
    drive(op, a, b);
    #1;
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'h0000_0003;
    for (int unsigned i = 1; i < lat; i++) begin
      check({tag, "_busy_valid"}, {31'd0, bus.out_valid}, 32'd0);
      check({tag, "_busy_ready"}, {31'd0, bus.in_ready}, 32'd0);
      tick();
    end
    check({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_br"}, {31'd0, bus.br_cond}, {31'd0, exp_br});
    check({tag, "_illegal"}, {31'd0, bus.illegal}, 32'd0);
    tick();
    check({tag, "_retire"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_br", {31'd0, bus.br_cond}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    check("rst_cnt", {27'd0, dut.cnt_q}, 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

    run_op("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1'b0);
    run_op("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32, 32'hFFFF_FFFF, 1'b0);
    run_op("srl4", ALU_SRL, 32'h8000_0000, 32'd4, 5, 32'h0800_0000, 1'b0);
    run_op("srl0", ALU_SRL, 32'h8000_0000, 32'd0, 1, 32'h8000_0000, 1'b0);
    run_op("sll1", ALU_SLL, 32'h0000_0001, 32'h0000_0021, 2, 32'h0000_0002, 1'b0);
    run_op("sub", ALU_SUB, 32'd10, 32'd3, 1, 32'd7, 1'b0);
    run_op("noteq_eq", ALU_NOTEQ, 32'd4, 32'd4, 1, 32'd0, 1'b0);
    run_op("noteq_ne", ALU_NOTEQ, 32'd4, 32'd5, 1, 32'd1, 1'b1);
    run_op("sge", ALU_SGE, 32'hFFFF_FFFF, 32'd1, 1, 32'd0, 1'b0);
    run_op("sgeu", ALU_SGEU, 32'hFFFF_FFFF, 32'd1, 1, 32'd1, 1'b1);
    run_op("xor", ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0);
    run_op("or", ALU_OR, 32'h0F0F_0000, 32'h0000_00F0, 1, 32'h0F0F_00F0, 1'b0);
    run_op("and", ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0);

    // Back-to-back SLTU then SLT on the same operands.
    bus.out_ready = 1'b1;
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
    tick();
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    #1;
    check("sltu_valid", {31'd0, bus.out_valid}, 32'd1);
    check("sltu_result", bus.result, 32'd0);
    check("sltu_br", {31'd0, bus.br_cond}, 32'd0);
    check("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("slt_valid", {31'd0, bus.out_valid}, 32'd1);
    check("slt_result", bus.result, 32'd1);
    check("slt_br", {31'd0, bus.br_cond}, 32'd1);
    tick();
    check("slt_retire", {31'd0, bus.out_valid}, 32'd0);

    // SUB held in DONE while the consumer stalls; later input changes ignored.
    bus.out_ready = 1'b0;
    drive(ALU_SUB, 32'd5, 32'd5);
    tick();
    bus.in_valid = 1'b0;
    bus.alu_ctrl = ALU_ADD;
    bus.op_a     = 32'h1234_5678;
    bus.op_b     = 32'h1111_1111;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i == 3) bus.out_ready = 1'b1;
      #1;
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_result", bus.result, 32'd0);
      check("hold_br", {31'd0, bus.br_cond}, 32'd1);
      check("hold_in_ready", {31'd0, bus.in_ready}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("hold_retire", {31'd0, bus.out_valid}, 32'd0);

    // SLL 10 killed by flush, then ADD 2+3.
    drive(ALU_SLL, 32'h1, 32'd10);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    bus.flush = 1'b1;
    drive(ALU_ADD, 32'd7, 32'd7);
    #1;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      check("flush_no_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    run_op("add_after_flush", ALU_ADD, 32'd2, 32'd3, 1, 32'd5, 1'b0);

    // Same sequence with reset in place of flush.
    drive(ALU_SLL, 32'h1, 32'd10);
    tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    drive(ALU_ADD, 32'd7, 32'd7);
    #1;
    check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_mid_result", bus.result, 32'd0);
    check("rst_mid_cnt", {27'd0, dut.cnt_q}, 32'd0);
    for (int unsigned i = 0; i < 12; i++) begin
      check("rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end
    run_op("add_after_rst", ALU_ADD, 32'd2, 32'd3, 1, 32'd5, 1'b0);

    // Illegal code then JUMP back-to-back.
    bus.out_ready = 1'b1;
    drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    drive(ALU_JUMP, 32'h0000_0100, 32'h0000_0055);
    #1;
    check("ill_valid", {31'd0, bus.out_valid}, 32'd1);
    check("ill_flag", {31'd0, bus.illegal}, 32'd1);
    check("ill_result", bus.result, 32'd0);
    check("ill_br", {31'd0, bus.br_cond}, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    check("jump_valid", {31'd0, bus.out_valid}, 32'd1);
    check("jump_result", bus.result, 32'h0000_0104);
    check("jump_illegal", {31'd0, bus.illegal}, 32'd0);
    tick();
    check("jump_retire", {31'd0, bus.out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 in_valid  input  1  operation offered.
REQ-005 in_ready  output  1  unit can accept an operation this cycle.
REQ-006 alu_ctrl  input  4  operation code, values from the shared define file: ADD, SUB, NOTEQ, SLT, SGE, SLTU, SGEU, SLL, SRL, SRA, XOR, OR, AND, JUMP; 4'b1111 is illegal.
REQ-007 op_a  input  32  first operand; carries the PC for JUMP.
REQ-008 op_b  input  32  second operand; shift amount is op_b[4:0].
REQ-009 flush  input  1  kill any accepted, uncompleted operation.
REQ-010 out_valid  output  1  result registers hold a completed operation.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  32  operation result.
REQ-013 br_cond  output  1  branch condition for SUB/NOTEQ/SLT/SGE/SLTU/SGEU.
REQ-014 illegal  output  1  completed operation had an unrecognised code.

Function
REQ-015 SHALL use FSM states IDLE, SHIFT, DONE; acceptance occurs when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE, and 1 in DONE when out_ready is 1; otherwise 0.
REQ-017 Non-shift ops SHALL go from IDLE to DONE with out_valid asserted the cycle after acceptance (latency 1).
REQ-018 Results SHALL be: ADD a+b; SUB a-b; XOR/OR/AND bitwise; SLT/SLTU signed/unsigned a<b as 1/0; SGE/SGEU the complement of SLT/SLTU; NOTEQ (a!=b) as 1/0; JUMP a+32'd4. Arithmetic is mod 2^32 with no carry or overflow output.
REQ-019 br_cond SHALL be (a==b) for SUB, and result[0] for NOTEQ/SLT/SGE/SLTU/SGEU; otherwise 0.
REQ-020 SLL/SRL/SRA SHALL be iterative, shifting 1 bit per cycle in SHIFT: latency = shamt+1, or 1 when shamt=0 (straight to DONE). SRA SHALL replicate bit 31.
REQ-021 An illegal code SHALL complete with latency 1: result=0, br_cond=0, illegal=1.
REQ-022 In DONE, outputs SHALL hold stable until out_ready is 1. If out_ready and in_valid are both 1, the next operation SHALL be accepted in the same cycle (back-to-back, no bubble).
REQ-023 On DONE with out_ready=1 and no new op, the FSM SHALL return to IDLE and out_valid SHALL drop.
REQ-024 flush SHALL force IDLE with out_valid=0 next cycle, discarding any SHIFT/DONE content. in_ready SHALL be 0 while flush=1, so no op is accepted in the flush cycle.
REQ-025 Inputs SHALL be captured at acceptance; later changes to alu_ctrl/op_a/op_b SHALL NOT affect the result.

Reset
REQ-026 rst=1 SHALL take precedence over every other input, including mid-SHIFT.
REQ-027 During rst=1 and on the first cycle after it, the unit SHALL be in IDLE with out_valid=0, result=0, br_cond=0, illegal=0, and the shift counter at 0.
REQ-028 in_ready SHALL be 0 while rst=1.

Structure
REQ-029 alu_ctrl code macros SHALL come only from the shared define file; the FSM state encodings SHALL be added there as named constants.
REQ-030 The combinational single-cycle datapath (REQ-018/019) SHALL be one sub-module, alu_comb. The FSM, shift counter and output registers SHALL live in alu_exec_unit.

Verification
REQ-031 ADD a=0x7FFFFFFF, b=1, out_ready=1 -> out_valid next cycle, result=0x80000000, br_cond=0.
REQ-032 SRA a=0x80000000, b=31 -> out_valid 32 cycles after acceptance, result=0xFFFFFFFF, in_ready=0 throughout SHIFT.
REQ-033 SLTU a=0xFFFFFFFF, b=1 then SLT on the same operands, back-to-back with out_ready=1 -> results 0 then 1, no idle cycle between out_valid pulses.
REQ-034 SUB a=b=5 with out_ready held 0 for 3 cycles -> result=0 and br_cond=1 stable for 4 cycles, then accepted.
REQ-035 SLL b=10 with flush asserted at cycle 4 -> no out_valid. A following ADD 2+3 -> result 5. Repeat with rst instead of flush -> same outcome.
REQ-036 alu_ctrl=4'b1111 -> out_valid after 1 cycle, illegal=1, result=0. JUMP a=0x100 -> result=0x104.
